// File: rtl/spi_msg_sequencer_if.sv
// Word-level handshake between the SPI slave shifter and the message sequencer.
interface spi_msg_sequencer_if;
  logic        msg_start;
  logic        msg_idle;
  logic        word_valid;
  logic [31:0] rx_word;
  logic [31:0] tx_word;

  modport master (
    output msg_start,
    output msg_idle,
    output word_valid,
    output rx_word,
    input  tx_word
  );

  modport slave (
    input  msg_start,
    input  msg_idle,
    input  word_valid,
    input  rx_word,
    output tx_word
  );
endinterface

// File: rtl/spi_msg_sequencer.sv
// Frames SSEL-delimited SPI messages, stages PWM duties for atomic commit,
// serves status and counter snapshots on TX, and zeroes PWM on watchdog expiry.
module spi_msg_sequencer #(
  parameter int unsigned NPWM       = 4,
  parameter int unsigned NQ         = 4,
  parameter int unsigned WDT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_msg_sequencer_if.slave   spi,
  input  logic [32*NQ-1:0]     qcnt_in,
  output logic [32*NPWM-1:0]   pwm_out,
  output logic                 pwm_update,
  output logic                 wdt_trip,
  output logic [7:0]           err_cnt,
  output logic [7:0]           seq
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DRAIN
  } state_t;

  localparam logic [3:0]  LAST_K    = 4'(NPWM - 1);
  localparam logic [3:0]  LAST_SLOT = 4'(NQ + 1);
  localparam logic [23:0] WDT_LAST  = 24'(WDT_CYCLES - 1);

  state_t          state;
  state_t          state_nxt;

  logic            idle_q;
  logic            idle_rise;
  logic            in_msg;
  logic            abort;
  logic            msg_end;
  logic            word_acc;
  logic            commit;
  logic            reject;
  logic            hdr_ok;
  logic            wdt_expire;
  logic            msg_good;

  logic [NPWM-1:0] mask;
  logic [31:0]     staging [NPWM];
  logic [31:0]     pwm_r   [NPWM];
  logic [31:0]     snap    [NQ];
  logic [3:0]      k_idx;
  logic [3:0]      slot;
  logic [23:0]     wdt_cnt;
  logic [31:0]     tx_word_c;

  assign hdr_ok     = (spi.rx_word[31:24] == 8'hA5);
  assign wdt_expire = (wdt_cnt >= WDT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Event decode and next state; msg_start outranks both message end and a
  // coincident word, and a message end outranks a coincident word.
  always_comb begin
    state_nxt = state;
    in_msg    = (state != IDLE);
    idle_rise = spi.msg_idle & ~idle_q;
    abort     = spi.msg_start & in_msg;
    msg_end   = in_msg & idle_rise & ~spi.msg_start;
    word_acc  = in_msg & spi.word_valid & ~spi.msg_start & ~msg_end;
    commit    = msg_end & (state == DRAIN) & msg_good;
    reject    = abort | (msg_end & ~commit);

    if (spi.msg_start) begin
      state_nxt = HDR;
    end else if (msg_end) begin
      state_nxt = IDLE;
    end else if (word_acc) begin
      case (state)
        HDR:     state_nxt = hdr_ok ? DATA : DRAIN;
        DATA:    if (k_idx == LAST_K) state_nxt = DRAIN;
        default: state_nxt = state;
      endcase
    end
  end

  // Outgoing word for the current transfer slot
  always_comb begin
    tx_word_c = '0;
    if (state != IDLE) begin
      if (slot == 4'd0) begin
        tx_word_c = {8'h5A, err_cnt, seq, 7'b0, wdt_trip};
      end else begin
        for (int unsigned j = 0; j < NQ; j++) begin
          if (slot == 4'(j + 1)) tx_word_c = snap[j];
        end
      end
    end
  end

  assign spi.tx_word = tx_word_c;

  always_comb begin
    pwm_out = '0;
    for (int unsigned j = 0; j < NPWM; j++) begin
      pwm_out[32*j +: 32] = pwm_r[j];
    end
  end

  // Message datapath, commit and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q     <= 1'b0;
      msg_good   <= 1'b0;
      mask       <= '0;
      k_idx      <= '0;
      slot       <= '0;
      wdt_cnt    <= '0;
      wdt_trip   <= 1'b1;
      pwm_update <= 1'b0;
      err_cnt    <= '0;
      seq        <= '0;
      for (int unsigned j = 0; j < NPWM; j++) begin
        staging[j] <= '0;
        pwm_r[j]   <= '0;
      end
      for (int unsigned i = 0; i < NQ; i++) begin
        snap[i] <= '0;
      end
    end else begin
      idle_q     <= spi.msg_idle;
      pwm_update <= commit;

      if (spi.msg_start) begin
        msg_good <= 1'b0;
        k_idx    <= '0;
        slot     <= '0;
        for (int unsigned i = 0; i < NQ; i++) begin
          snap[i] <= qcnt_in[32*i +: 32];
        end
      end else if (word_acc) begin
        if (slot != LAST_SLOT) slot <= slot + 4'd1;
        case (state)
          HDR: begin
            if (hdr_ok) mask <= spi.rx_word[NPWM-1:0];
          end
          DATA: begin
            for (int unsigned j = 0; j < NPWM; j++) begin
              if (k_idx == 4'(j)) staging[j] <= spi.rx_word;
            end
            k_idx <= k_idx + 4'd1;
            if (k_idx == LAST_K) msg_good <= 1'b1;
          end
          DRAIN: msg_good <= 1'b0;
          default: ;
        endcase
      end

      if (reject && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      // A commit on the expiry cycle wins: counter and trip clear, no zeroing.
      if (commit) begin
        seq      <= seq + 8'd1;
        wdt_cnt  <= '0;
        wdt_trip <= 1'b0;
        for (int unsigned j = 0; j < NPWM; j++) begin
          if (mask[j]) pwm_r[j] <= staging[j];
        end
      end else begin
        if (wdt_cnt != '1) wdt_cnt <= wdt_cnt + 24'd1;
        if (wdt_expire) begin
          wdt_trip <= 1'b1;
          for (int unsigned j = 0; j < NPWM; j++) begin
            pwm_r[j] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_msg_sequencer.sv
// Randomized message traffic against a message-level reference model of the
// SPI sequencer, plus directed scenarios with hand-computed expectations.
module tb_spi_msg_sequencer;
  localparam int unsigned NPWM = 4;
  localparam int unsigned NQ   = 4;
  localparam int unsigned WDT  = 1000;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic [32*NQ-1:0]     qcnt_in;
  logic [32*NPWM-1:0]   pwm_out;
  logic                 pwm_update;
  logic                 wdt_trip;
  logic [7:0]           err_cnt;
  logic [7:0]           seq;

  spi_msg_sequencer_if spi ();

  spi_msg_sequencer #(
    .NPWM       (NPWM),
    .NQ         (NQ),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi),
    .qcnt_in    (qcnt_in),
    .pwm_out    (pwm_out),
    .pwm_update (pwm_update),
    .wdt_trip   (wdt_trip),
    .err_cnt    (err_cnt),
    .seq        (seq)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          rand_q = 1'b0;
  logic [31:0] mq[$];

  // Reference model: message state is just "inside a message" plus the list
  // of words received so far; good means header magic and exactly NPWM payload words.
  logic [31:0] m_pwm  [NPWM];
  logic [31:0] m_snap [NQ];
  logic [31:0] m_words[$];
  bit          m_in, m_prev_idle, m_upd, m_trip;
  int unsigned m_err, m_seq, m_cyc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < NPWM; j++) m_pwm[j] = '0;
    for (int i = 0; i < NQ; i++) m_snap[i] = '0;
    m_words.delete();
    m_in = 0; m_prev_idle = 0; m_upd = 0; m_trip = 1;
    m_err = 0; m_seq = 0; m_cyc = 0;
  endfunction

  function automatic void err_inc();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_update(bit ms, bit idle, bit wv, logic [31:0] rx,
                                       logic [32*NQ-1:0] q);
    bit rise, commit;
    logic [31:0] hdr;
    rise = idle && !m_prev_idle;
    m_prev_idle = idle;
    commit = 0;
    if (ms) begin
      if (m_in) err_inc();
      m_in = 1;
      m_words.delete();
      for (int i = 0; i < NQ; i++) m_snap[i] = q[32*i +: 32];
    end else if (m_in && rise) begin
      m_in = 0;
      hdr = (m_words.size() > 0) ? m_words[0] : 32'h0;
      if (m_words.size() == NPWM + 1 && hdr[31:24] == 8'hA5) begin
        commit = 1;
        for (int j = 0; j < NPWM; j++) if (hdr[j]) m_pwm[j] = m_words[j+1];
        m_seq = (m_seq + 1) % 256;
      end else begin
        err_inc();
      end
    end else if (m_in && wv) begin
      m_words.push_back(rx);
    end
    m_upd = commit;
    if (commit) begin
      m_cyc = 0;
      m_trip = 0;
    end else begin
      m_cyc++;
      if (m_cyc >= WDT) begin
        m_trip = 1;
        for (int j = 0; j < NPWM; j++) m_pwm[j] = '0;
      end
    end
  endfunction

  function automatic logic [32*NPWM-1:0] exp_pwm();
    logic [32*NPWM-1:0] p;
    for (int j = 0; j < NPWM; j++) p[32*j +: 32] = m_pwm[j];
    return p;
  endfunction

  function automatic logic [31:0] exp_tx();
    int unsigned s;
    s = m_words.size();
    if (s == 0) return {8'h5A, 8'(m_err), 8'(m_seq), 7'b0, m_trip};
    if (s <= NQ) return m_snap[s-1];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    chk("pwm_out", pwm_out, exp_pwm());
    chk("pwm_update", pwm_update, m_upd);
    chk("wdt_trip", wdt_trip, m_trip);
    chk("err_cnt", err_cnt, 8'(m_err));
    chk("seq", seq, 8'(m_seq));
    if (m_in) chk("tx_word", spi.tx_word, exp_tx());
  end

  // One clock of stimulus; the model advances right after the edge it describes.
  task automatic step(input bit ms, input bit idle, input bit wv, input logic [31:0] rx);
    logic [32*NQ-1:0] q;
    bit r;
    if (rand_q) for (int i = 0; i < NQ; i++) qcnt_in[32*i +: 32] = $urandom;
    spi.msg_start  = ms;
    spi.msg_idle   = idle;
    spi.word_valid = wv;
    spi.rx_word    = rx;
    q = qcnt_in;
    r = rst_n;
    @(posedge clk);
    #1;
    if (r) model_update(ms, idle, wv, rx, q);
    spi.msg_start  = 1'b0;
    spi.word_valid = 1'b0;
  endtask

  task automatic send_msg(input bit do_end, input int unsigned max_gap);
    step(1'b1, 1'b0, rand_q ? 1'($urandom_range(1)) : 1'b0, $urandom);
    foreach (mq[i]) begin
      repeat ($urandom_range(max_gap)) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, mq[i]);
    end
    if (do_end) begin
      repeat ($urandom_range(max_gap)) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned kind, cnt;
    logic [31:0] hdr;
    spi.msg_start = 1'b0; spi.msg_idle = 1'b1; spi.word_valid = 1'b0; spi.rx_word = '0;
    qcnt_in = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst pwm_out", pwm_out, 0);
    chk("rst wdt_trip", wdt_trip, 1);
    chk("rst tx_word", spi.tx_word, 0);
    chk("rst err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // All four registers written
    mq = {32'hA500000F, 32'd1, 32'd2, 32'd3, 32'd4};
    send_msg(1'b1, 0);
    chk("t1 pwm_out", pwm_out, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t1 pwm_update", pwm_update, 1);
    chk("t1 seq", seq, 1);
    chk("t1 wdt_trip", wdt_trip, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t1 pwm_update low", pwm_update, 0);

    // Snapshots taken at msg_start, later counter changes ignored
    qcnt_in = {32'h44, 32'h33, 32'h22, 32'h11};
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("slot0", spi.tx_word, 32'h5A000100);
    qcnt_in = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
    step(1'b0, 1'b0, 1'b1, 32'hA5000000);
    chk("slot1", spi.tx_word, 32'h11);
    step(1'b0, 1'b0, 1'b1, 32'd1);
    chk("slot2", spi.tx_word, 32'h22);
    step(1'b0, 1'b0, 1'b1, 32'd2);
    chk("slot3", spi.tx_word, 32'h33);
    step(1'b0, 1'b0, 1'b1, 32'd3);
    chk("slot4", spi.tx_word, 32'h44);
    step(1'b0, 1'b0, 1'b1, 32'd4);
    chk("slot5", spi.tx_word, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Partial mask
    mq = {32'hA5000005, 32'd10, 32'd20, 32'd30, 32'd40};
    send_msg(1'b1, 1);
    chk("t2 pwm_out", pwm_out, {32'd4, 32'd30, 32'd2, 32'd10});
    chk("t2 seq", seq, 3);

    // Bad magic, short, long
    mq = {32'h12000001, 32'd7, 32'd7, 32'd7, 32'd7};
    send_msg(1'b1, 1);
    mq = {32'hA500000F, 32'd7, 32'd7, 32'd7};
    send_msg(1'b1, 1);
    mq = {32'hA500000F, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    send_msg(1'b1, 1);
    chk("bad err_cnt", err_cnt, 3);
    chk("bad pwm_out", pwm_out, {32'd4, 32'd30, 32'd2, 32'd10});

    // Abort mid-message with a coincident word, then a good restart
    mq = {32'hA500000F, 32'd9, 32'd9};
    send_msg(1'b0, 0);
    spi.msg_idle = 1'b0;
    mq = {32'hA5000002, 32'd100, 32'd200, 32'd300, 32'd400};
    step(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
    foreach (mq[i]) step(1'b0, 1'b0, 1'b1, mq[i]);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("abort err_cnt", err_cnt, 4);
    chk("abort pwm_out", pwm_out, {32'd4, 32'd30, 32'd200, 32'd10});
    chk("abort seq", seq, 4);

    // Watchdog expiry exactly WDT cycles after the last commit
    repeat (WDT - 1) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wdt before trip", wdt_trip, 0);
    chk("wdt before pwm", pwm_out, {32'd4, 32'd30, 32'd200, 32'd10});
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wdt trip", wdt_trip, 1);
    chk("wdt pwm zero", pwm_out, 0);
    mq = {32'hA500000F, 32'd5, 32'd6, 32'd7, 32'd8};
    send_msg(1'b1, 0);
    chk("wdt cleared", wdt_trip, 0);
    chk("wdt recommit", pwm_out, {32'd8, 32'd7, 32'd6, 32'd5});

    // Reset during DATA
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hA500000F);
    step(1'b0, 1'b0, 1'b1, 32'd55);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid rst pwm_out", pwm_out, 0);
    chk("mid rst seq", seq, 0);
    chk("mid rst wdt_trip", wdt_trip, 1);
    chk("mid rst tx_word", spi.tx_word, 0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    mq = {32'hA500000F, 32'd11, 32'd12, 32'd13, 32'd14};
    send_msg(1'b1, 0);
    chk("post rst pwm_out", pwm_out, {32'd14, 32'd13, 32'd12, 32'd11});
    chk("post rst seq", seq, 1);

    // seq wraps 255 -> 0
    mq = {32'hA5000000, 32'd0, 32'd0, 32'd0, 32'd0};
    repeat (255) send_msg(1'b1, 0);
    chk("seq wrap", seq, 0);

    // err_cnt saturates
    mq = {32'h12000001};
    repeat (256) send_msg(1'b1, 0);
    chk("err saturate", err_cnt, 255);

    // Randomized traffic
    rand_q = 1'b1;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(5);
      hdr  = $urandom;
      cnt  = 0;
      case (kind)
        0, 1: begin hdr[31:24] = 8'hA5; cnt = NPWM; end
        2: begin
          if (hdr[31:24] == 8'hA5) hdr[31:24] = 8'h00;
          cnt = $urandom_range(NPWM + 2);
        end
        3: begin hdr[31:24] = 8'hA5; cnt = $urandom_range(NPWM - 1); end
        4: begin hdr[31:24] = 8'hA5; cnt = NPWM + 1 + $urandom_range(2); end
        default: begin hdr[31:24] = 8'hA5; cnt = $urandom_range(NPWM); end
      endcase
      mq.delete();
      mq.push_back(hdr);
      for (int i = 0; i < int'(cnt); i++) mq.push_back($urandom);
      send_msg(kind != 5, 2);
      repeat ($urandom_range(3))
        step(1'b0, kind != 5, 1'($urandom_range(1)), $urandom);
    end
    repeat (WDT + 5) step(1'b0, 1'b1, 1'b0, 32'h0);
    mq = {32'hA500000F, $urandom, $urandom, $urandom, $urandom};
    send_msg(1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
